// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI responder: register TXCMDs against a 64x8 file, NOPID transmit capture,
// and injection of receive packets / standalone RXCMDs toward the link.
module ulpi_phy_emu #(
  parameter logic [15:0] VENDOR_ID    = 16'h0424,
  parameter logic [15:0] PRODUCT_ID   = 16'h0009,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_LAST,
  input  logic       RX_ERR,
  output logic       RX_READY,
  input  logic [3:0] RXCMD_IN,
  input  logic       RXCMD_STRB,
  output logic       TX_START,
  output logic [3:0] TX_PID,
  output logic [7:0] TX_DATA,
  output logic       TX_STRB,
  output logic       TX_END,
  output logic       REG_WR_STRB,
  output logic [5:0] REG_WR_ADDR,
  output logic [7:0] REG_WR_DATA,
  output logic [3:0] STATE
);
  typedef enum logic [3:0] {
    ST_RST_HOLD, ST_IDLE, ST_CMD_ACK, ST_WR_DATA, ST_WR_STP, ST_RD_TURN, ST_RD_DATA,
    ST_RD_BACK, ST_TX_DATA, ST_RX_TURN, ST_RX_CMD, ST_RX_BYTE, ST_RX_TAIL, ST_RX_BACK
  } state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_TX} op_t;

  localparam logic [15:0] CNT_LAST = 16'(RESET_CYCLES - 1);

  state_t      st, nxt_st;
  op_t         op_q, idle_op;
  logic [15:0] rst_cnt;
  logic [5:0]  addr_q;
  logic [7:0]  wr_data_q, rd_val, dout_nx;
  logic [7:0]  regs [64];
  logic [3:0]  rxcmd_q;
  logic        cmd_pend, pkt_q, last_q, err_q, last_nx;
  logic        commit, soft_rst, consume, dir_nx, nxt_nx, rx_pend;

  function automatic logic [7:0] reg_default(input logic [5:0] a);
    case (a)
      6'h04:   return 8'h41;
      6'h0A:   return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  assign rx_pend = RX_VALID | cmd_pend;
  assign consume = RX_READY & RX_VALID;
  assign STATE   = st;

  always_comb begin
    idle_op = OP_TX;
    if (ULPI_DATA_I[7:6] == 2'b10)      idle_op = OP_WR;
    else if (ULPI_DATA_I[7:6] == 2'b11) idle_op = OP_RD;
  end

  always_comb begin
    case (addr_q)
      6'h00:   rd_val = VENDOR_ID[7:0];
      6'h01:   rd_val = VENDOR_ID[15:8];
      6'h02:   rd_val = PRODUCT_ID[7:0];
      6'h03:   rd_val = PRODUCT_ID[15:8];
      default: rd_val = regs[addr_q];
    endcase
  end

  always_comb begin
    nxt_st   = st;
    commit   = 1'b0;
    soft_rst = 1'b0;
    case (st)
      ST_RST_HOLD: if (rst_cnt == CNT_LAST) nxt_st = ST_IDLE;
      // The PHY owns the bus first; a TXCMD colliding with a pending RX is dropped.
      ST_IDLE: begin
        if (rx_pend) nxt_st = ST_RX_TURN;
        else if (ULPI_DATA_I[7] || ULPI_DATA_I[7:4] == 4'b0100) nxt_st = ST_CMD_ACK;
      end
      ST_CMD_ACK: begin
        case (op_q)
          OP_WR:   nxt_st = ST_WR_DATA;
          OP_RD:   nxt_st = ST_RD_TURN;
          default: nxt_st = ST_TX_DATA;
        endcase
      end
      ST_WR_DATA: nxt_st = ST_WR_STP;
      ST_WR_STP: begin
        if (ULPI_STP) begin
          commit   = (addr_q > 6'd3);
          soft_rst = commit && (addr_q == 6'h04) && wr_data_q[5];
          nxt_st   = soft_rst ? ST_RST_HOLD : ST_IDLE;
        end
      end
      ST_RD_TURN: nxt_st = ST_RD_DATA;
      ST_RD_DATA: nxt_st = ST_RD_BACK;
      ST_RD_BACK: nxt_st = ST_IDLE;
      ST_TX_DATA: if (ULPI_STP) nxt_st = ST_IDLE;
      ST_RX_TURN: nxt_st = ST_RX_CMD;
      ST_RX_CMD:  nxt_st = pkt_q ? ST_RX_BYTE : ST_RX_BACK;
      ST_RX_BYTE: if (last_q) nxt_st = ST_RX_TAIL;
      ST_RX_TAIL: nxt_st = ST_RX_BACK;
      ST_RX_BACK: nxt_st = ST_IDLE;
      default:    nxt_st = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the state being entered, so they line up with it.
  always_comb begin
    last_nx = (nxt_st == ST_RX_TURN) ? 1'b0 : (last_q | (consume & RX_LAST));
    dir_nx  = nxt_st inside {ST_RST_HOLD, ST_RD_TURN, ST_RD_DATA, ST_RX_TURN,
                             ST_RX_CMD, ST_RX_BYTE, ST_RX_TAIL};
    nxt_nx  = 1'b0;
    dout_nx = 8'h00;
    case (nxt_st)
      ST_CMD_ACK, ST_WR_DATA, ST_TX_DATA: nxt_nx = 1'b1;
      ST_RD_DATA: dout_nx = rd_val;
      ST_RX_CMD:  dout_nx = {3'b000, pkt_q, rxcmd_q};
      ST_RX_BYTE: begin
        nxt_nx  = consume;
        dout_nx = consume ? RX_DATA : {4'b0001, rxcmd_q};
      end
      ST_RX_TAIL: dout_nx = {2'b00, err_q, err_q, rxcmd_q};
      default: ;
    endcase
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      st           <= ST_RST_HOLD;
      op_q         <= OP_WR;
      rst_cnt      <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rxcmd_q      <= '0;
      cmd_pend     <= 1'b0;
      pkt_q        <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      ULPI_DIR     <= 1'b1;
      ULPI_DATA_OE <= 1'b0;
      ULPI_NXT     <= 1'b0;
      ULPI_DATA_O  <= '0;
      RX_READY     <= 1'b0;
      TX_START     <= 1'b0;
      TX_PID       <= '0;
      TX_DATA      <= '0;
      TX_STRB      <= 1'b0;
      TX_END       <= 1'b0;
      REG_WR_STRB  <= 1'b0;
      REG_WR_ADDR  <= '0;
      REG_WR_DATA  <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= reg_default(6'(i));
    end else begin
      st      <= nxt_st;
      rst_cnt <= (st == ST_RST_HOLD && nxt_st == ST_RST_HOLD) ? rst_cnt + 16'd1 : 16'd0;
      if (st == ST_IDLE && nxt_st == ST_CMD_ACK) begin
        addr_q <= ULPI_DATA_I[5:0];
        op_q   <= idle_op;
        if (idle_op == OP_TX) TX_PID <= ULPI_DATA_I[3:0];
      end
      TX_START <= (st == ST_IDLE) && (nxt_st == ST_CMD_ACK) && (idle_op == OP_TX);
      if (st == ST_WR_DATA) wr_data_q <= ULPI_DATA_I;
      REG_WR_STRB <= commit;
      if (commit) begin
        REG_WR_ADDR <= addr_q;
        REG_WR_DATA <= wr_data_q;
      end
      if (soft_rst) for (int i = 0; i < 64; i++) regs[i] <= reg_default(6'(i));
      else if (commit) regs[addr_q] <= wr_data_q;
      TX_STRB <= (st == ST_TX_DATA) && !ULPI_STP;
      TX_END  <= (st == ST_TX_DATA) && ULPI_STP;
      if (st == ST_TX_DATA && !ULPI_STP) TX_DATA <= ULPI_DATA_I;
      // One standalone RXCMD can wait while the bus is busy.
      if (RXCMD_STRB) cmd_pend <= 1'b1;
      else if (nxt_st == ST_RX_TURN) cmd_pend <= 1'b0;
      if (RXCMD_STRB) rxcmd_q <= RXCMD_IN;
      else if (st == ST_IDLE && nxt_st == ST_RX_TURN && !cmd_pend) rxcmd_q <= RXCMD_IN;
      if (st == ST_IDLE && nxt_st == ST_RX_TURN) begin
        pkt_q <= RX_VALID;
        err_q <= 1'b0;
      end else if (consume && RX_LAST) begin
        err_q <= RX_ERR;
      end
      last_q       <= last_nx;
      RX_READY     <= (nxt_st == ST_RX_CMD && pkt_q) || (nxt_st == ST_RX_BYTE && !last_nx);
      ULPI_DIR     <= dir_nx;
      ULPI_DATA_OE <= dir_nx && ULPI_DIR && (nxt_st != ST_RST_HOLD);
      ULPI_NXT     <= nxt_nx;
      ULPI_DATA_O  <= dout_nx;
    end
  end
endmodule
